mem_port_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_fairness.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: FSM encoding and
// default bus widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int STREAK_W   = 4;

endpackage

// File: rtl/mem_arb_fairness.sv
// Priority decision between fetch and data requesters, with a data-grant
// streak counter that hands the port to a waiting fetch after MAX_D_STREAK.
module mem_arb_fairness
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic                i_elig,
  input  logic                d_elig,
  input  logic                arb_en,
  output logic                grant_i,
  output logic                grant_d,
  output logic [STREAK_W-1:0] streak
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic at_max;
  assign at_max = (streak == STREAK_MAX);

  // Data wins a tie unless it has already taken the port MAX_D_STREAK times.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (arb_en) begin
      if (d_elig && !(i_elig && at_max)) begin
        grant_d = 1'b1;
      end else if (i_elig) begin
        grant_i = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!i_req || grant_i) begin
      streak <= '0;
    end else if (grant_d && !at_max) begin
      streak <= streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port variable-latency memory between the IF and MEM
// pipeline stages; returns read data with a one-cycle ack and drives stalls.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output state_t              dbg_state,
  output logic [STREAK_W-1:0] dbg_streak
);

  // Handshake: a requester raises req and holds it with stable fields until
  // its ack pulses for one cycle; the memory completes a held mem_req by
  // asserting mem_ready for one cycle, and mem_ready is ignored otherwise.

  state_t state, state_next;
  logic   i_elig, d_elig;
  logic   grant_i, grant_d;
  logic   i_done, d_done;

  assign i_elig    = i_req & ~i_ack;
  assign d_elig    = d_req & ~d_ack;
  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;
  assign mem_req   = (state != IDLE);
  assign i_done    = (state == I_WAIT) & mem_ready;
  assign d_done    = (state == D_WAIT) & mem_ready;
  assign dbg_state = state;

  mem_arb_fairness #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_fairness (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .i_elig (i_elig),
    .d_elig (d_elig),
    .arb_en (state == IDLE),
    .grant_i(grant_i),
    .grant_d(grant_d),
    .streak (dbg_streak)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = D_WAIT;
        end else if (grant_i) begin
          state_next = I_WAIT;
        end
      end
      I_WAIT:  if (mem_ready) state_next = IDLE;
      D_WAIT:  if (mem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_next;
      i_ack <= i_done;
      d_ack <= d_done;
      if (i_done) begin
        i_rdata <= mem_rdata;
      end
      // Stores complete without touching the load-data register.
      if (d_done && !mem_we) begin
        d_rdata <= mem_rdata;
      end
      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end
    end
  end

endmodule
